qspi_shift_reg: RTL and testbench

//  Data path of the QSPI master; sits directly beside the clock generator.
//  - Consumes the generator's pos_edge/neg_edge strobes to shift TX data onto sd_o and sample sd_i.
//  - Drives the generator's enable (tip_o) and last_clk (last_clk_o).
//  - Supports single-lane (1 bit/edge) and quad-lane (4 bits/edge), MSB- or LSB-first, up to MAX_CHAR bits per transfer.

---
 rtl/qspi_shift_reg.sv | 221 ++++++++++++++++++++++
 tb/tb_qspi_shift_reg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_shift_reg.sv
// qspi_shift_reg: QSPI master data path beside the clock generator.
// Shifts TX data onto sd_o on the selected generator strobe and samples sd_i
// on the other selected strobe. Supports 1 or 4 lanes, MSB/LSB first, and up
// to MAX_CHAR bits per transfer.
// Ports: clk_i/rst_ni (async active-low); go_i starts a transfer; char_len_i,
// lsb_i, quad_i, quad_rx_i are latched on go; tx/rx_negedge_i pick strobes;
// pos/neg_edge_i come from the generator; wr_en_i/wr_idx_i/wdata_i load TX
// words while idle; rd_idx_i/rdata_o read RX words (rdata_o combinational);
// sd_i/sd_o/sd_oe_o are the pads; tip_o, last_clk_o drive the generator;
// done_o pulses once at the end of a transfer.
// Optional: QSPI_SHIFT_LOOPBACK_EN adds loopback_i (RX from registered sd_o,
// output enables forced off).
module qspi_shift_reg #(
    parameter int unsigned MAX_CHAR = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          go_i,
    input  logic [$clog2(MAX_CHAR)-1:0]   char_len_i,
    input  logic                          lsb_i,
    input  logic                          quad_i,
    input  logic                          quad_rx_i,
    input  logic                          tx_negedge_i,
    input  logic                          rx_negedge_i,
    input  logic                          pos_edge_i,
    input  logic                          neg_edge_i,
    input  logic                          wr_en_i,
    input  logic [$clog2(MAX_CHAR/32)-1:0] wr_idx_i,
    input  logic [31:0]                   wdata_i,
    input  logic [$clog2(MAX_CHAR/32)-1:0] rd_idx_i,
    output logic [31:0]                   rdata_o,
`ifdef QSPI_SHIFT_LOOPBACK_EN
    input  logic                          loopback_i,
`endif
    input  logic [3:0]                    sd_i,
    output logic [3:0]                    sd_o,
    output logic [3:0]                    sd_oe_o,
    output logic                          tip_o,
    output logic                          last_clk_o,
    output logic                          done_o
);

    localparam int unsigned IDX_W = $clog2(MAX_CHAR/32);
    localparam int unsigned LEN_W = $clog2(MAX_CHAR);
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic {ST_IDLE, ST_XFER} state_e;

    state_e              state_q, state_d;
    logic [MAX_CHAR-1:0] tx_q, tx_d, rx_q, rx_d, tx_wr;
    logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, len_q, len_d;
    logic [CNT_W-1:0]    go_len, go_step, step_cur;
    logic [LEN_W-1:0]    go_raw, rx_base;
    logic                lsb_q, lsb_d, quad_q, quad_d, qrx_q, qrx_d;
    logic [3:0]          sd_q, sd_d, oe_q, oe_d, rx_lanes;
    logic                done_q, done_d, last_q, last_d;
    logic                tx_edge, rx_edge, go_acc, rx_last, rx_bit, lb_go;
`ifdef QSPI_SHIFT_LOOPBACK_EN
    logic                lb_q, lb_d;
`endif

    // Bit index of the lowest lane of the group at position count c.
    function automatic logic [LEN_W-1:0] grp_base(input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] len,
                                                  input logic lsb, input logic quad);
        logic [CNT_W-1:0] b;
        if (lsb) b = len - c;
        else     b = c - (quad ? CNT_W'(4) : CNT_W'(1));
        return LEN_W'(b);
    endfunction

    function automatic logic [3:0] tx_group(input logic [MAX_CHAR-1:0] d,
                                            input logic [LEN_W-1:0] base,
                                            input logic quad);
        return quad ? d[base +: 4] : {3'b000, d[base]};
    endfunction

    function automatic logic [3:0] lane_oe(input logic quad, input logic qrx, input logic lb);
        if (lb)    return 4'h0;
        if (!quad) return 4'h1;
        return qrx ? 4'h0 : 4'hF;
    endfunction

    // Strobe selection and transfer-level conditions.
    always_comb begin
        tx_edge  = tx_negedge_i ? neg_edge_i : pos_edge_i;
        rx_edge  = rx_negedge_i ? neg_edge_i : pos_edge_i;
        step_cur = quad_q ? CNT_W'(4) : CNT_W'(1);
        go_acc   = (state_q == ST_IDLE) && go_i;
        rx_last  = (state_q == ST_XFER) && rx_edge && (rx_cnt_q == step_cur);
        // Quad transfers are whole nibbles, so the low two length bits drop.
        go_raw   = quad_i ? {char_len_i[LEN_W-1:2], 2'b00} : char_len_i;
        go_len   = (go_raw == '0) ? CNT_W'(MAX_CHAR) : CNT_W'(go_raw);
        go_step  = quad_i ? CNT_W'(4) : CNT_W'(1);
    end

    // RX source; in loopback single-lane mode the bit comes back from sd_o[0].
    always_comb begin
`ifdef QSPI_SHIFT_LOOPBACK_EN
        lb_go    = loopback_i;
        rx_lanes = lb_q ? sd_q : sd_i;
        rx_bit   = lb_q ? sd_q[0] : sd_i[1];
`else
        lb_go    = 1'b0;
        rx_lanes = sd_i;
        rx_bit   = sd_i[1];
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go_i)    state_d = ST_XFER;
            ST_XFER: if (rx_last) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        rx_d     = rx_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        len_d    = len_q;
        lsb_d    = lsb_q;
        quad_d   = quad_q;
        qrx_d    = qrx_q;
        sd_d     = sd_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        rx_base  = '0;
`ifdef QSPI_SHIFT_LOOPBACK_EN
        lb_d     = lb_q;
`endif
        // A write in the go cycle is visible to the first group.
        tx_wr = tx_q;
        if (wr_en_i && (state_q == ST_IDLE)) tx_wr[{wr_idx_i, 5'b00000} +: 32] = wdata_i;
        tx_d = tx_wr;

        if (go_acc) begin
            len_d    = go_len;
            lsb_d    = lsb_i;
            quad_d   = quad_i;
            qrx_d    = quad_i & quad_rx_i;
`ifdef QSPI_SHIFT_LOOPBACK_EN
            lb_d     = loopback_i;
`endif
            rx_d     = '0;
            tx_cnt_d = go_len - go_step;
            rx_cnt_d = go_len;
            sd_d     = (quad_i && quad_rx_i) ? 4'h0 :
                       tx_group(tx_wr, grp_base(go_len, go_len, lsb_i, quad_i), quad_i);
            oe_d     = lane_oe(quad_i, quad_rx_i, lb_go);
        end else if (state_q == ST_XFER) begin
            if (tx_edge && (tx_cnt_q != '0)) begin
                sd_d     = qrx_q ? 4'h0 :
                           tx_group(tx_q, grp_base(tx_cnt_q, len_q, lsb_q, quad_q), quad_q);
                tx_cnt_d = tx_cnt_q - step_cur;
            end
            if (rx_edge) begin
                rx_base = grp_base(rx_cnt_q, len_q, lsb_q, quad_q);
                if (quad_q) rx_d[rx_base +: 4] = rx_lanes;
                else        rx_d[rx_base]      = rx_bit;
                rx_cnt_d = rx_cnt_q - step_cur;
            end
            if (rx_last) begin
                done_d = 1'b1;
                oe_d   = 4'h0;
            end
        end
        last_d = (state_d == ST_XFER) && (tx_cnt_d == '0);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            len_q    <= '0;
            lsb_q    <= 1'b0;
            quad_q   <= 1'b0;
            qrx_q    <= 1'b0;
            sd_q     <= 4'h0;
            oe_q     <= 4'h0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
`ifdef QSPI_SHIFT_LOOPBACK_EN
            lb_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            len_q    <= len_d;
            lsb_q    <= lsb_d;
            quad_q   <= quad_d;
            qrx_q    <= qrx_d;
            sd_q     <= sd_d;
            oe_q     <= oe_d;
            done_q   <= done_d;
            last_q   <= last_d;
`ifdef QSPI_SHIFT_LOOPBACK_EN
            lb_q     <= lb_d;
`endif
        end
    end

    assign sd_o       = sd_q;
    assign sd_oe_o    = oe_q;
    assign tip_o      = (state_q == ST_XFER);
    assign last_clk_o = last_q;
    assign done_o     = done_q;
    assign rdata_o    = rx_q[{rd_idx_i, 5'b00000} +: 32];

endmodule

// File: tb/tb_qspi_shift_reg.sv
// tb_qspi_shift_reg: randomized transfers of qspi_shift_reg against a
// bit-ordering reference model; the bench plays the clock generator.
`timescale 1ns/1ps
module tb_qspi_shift_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go, lsb, quad, quad_rx, tx_neg, rx_neg, pos_e, neg_e, wr_en;
    logic [5:0]  char_len;
    logic [0:0]  wr_idx, rd_idx;
    logic [31:0] wdata, rdata;
    logic [3:0]  sd_in, sd_o, sd_oe, sd_drv;
    logic        tip, last_clk, done;
    logic        ext_lb, ext_quad, lb_in;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [63:0] tx_model;

    always #5 clk = ~clk;

    // External wiring loopback: single lane returns sd_o[0] on sd_i[1].
    assign sd_in = !ext_lb ? sd_drv : (ext_quad ? sd_o : {2'b00, sd_o[0], 1'b0});

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    qspi_shift_reg #(.MAX_CHAR(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .go_i(go), .char_len_i(char_len),
        .lsb_i(lsb), .quad_i(quad), .quad_rx_i(quad_rx),
        .tx_negedge_i(tx_neg), .rx_negedge_i(rx_neg),
        .pos_edge_i(pos_e), .neg_edge_i(neg_e),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wdata_i(wdata),
        .rd_idx_i(rd_idx), .rdata_o(rdata),
`ifdef QSPI_SHIFT_LOOPBACK_EN
        .loopback_i(lb_in),
`endif
        .sd_i(sd_in), .sd_o(sd_o), .sd_oe_o(sd_oe),
        .tip_o(tip), .last_clk_o(last_clk), .done_o(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit position of lane k in group g of a transfer of len bits.
    function automatic int unsigned bit_pos(input int unsigned g, input int unsigned k,
                                            input int unsigned len, input int unsigned step,
                                            input bit l);
        return l ? (step * g + k) : (len - step * (g + 1) + k);
    endfunction

    function automatic logic [3:0] exp_grp(input logic [63:0] d, input int unsigned g,
                                           input int unsigned len, input int unsigned step,
                                           input bit l);
        logic [3:0] v;
        v = 4'h0;
        for (int k = 0; k < int'(step); k++)
            v[2'(k)] = d[6'(bit_pos(g, k, len, step, l))];
        return v;
    endfunction

    task automatic chk_sd(input string tag, input bit q, input logic [3:0] exp);
        if (q) chk(tag, 64'(sd_o), 64'(exp));
        else   chk(tag, 64'(sd_o[0]), 64'(exp[0]));
    endtask

    task automatic wr_word(input int idx, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 1'(idx); wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (idx == 0) tx_model[31:0] = d; else tx_model[63:32] = d;
    endtask

    task automatic garbage_in();
        go = 1'($urandom); wr_en = 1'($urandom); wr_idx = 1'($urandom); wdata = $urandom;
    endtask

    task automatic run_xfer(input int unsigned len_field, input bit l, input bit q, input bit qrx,
                            input bit txn, input bit rxn, input bit lb, input bit ilb,
                            input bit w0_en, input logic [31:0] w0,
                            input bit w1_en, input logic [31:0] w1,
                            input bit go_wr, input bit garbage);
        int unsigned len, step, n, tx_idx, rx_idx, done0;
        logic [63:0] exp_rx, mask;
        logic [3:0]  exp_oe, v, exp_sd;
        step   = q ? 4 : 1;
        len    = q ? (len_field & 32'd60) : len_field;
        if (len == 0) len = 64;
        n      = len / step;
        exp_rx = '0;
        mask   = (len == 64) ? '1 : ((64'd1 << len) - 64'd1);
        exp_oe = ilb ? 4'h0 : (!q ? 4'h1 : (qrx ? 4'h0 : 4'hF));
        ext_lb = lb && !ilb; ext_quad = q; sd_drv = 4'h0; lb_in = ilb;
        tx_neg = txn; rx_neg = rxn;
        if (w0_en) wr_word(0, w0);
        if (w1_en && !go_wr) wr_word(1, w1);
        @(negedge clk);
        char_len = len_field[5:0]; lsb = l; quad = q; quad_rx = qrx; go = 1'b1;
        if (w1_en && go_wr) begin
            wr_en = 1'b1; wr_idx = 1'b1; wdata = w1; tx_model[63:32] = w1;
        end
        done0 = done_cnt;
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        if (garbage) begin
            char_len = 6'($urandom); lsb = 1'($urandom); quad = 1'($urandom); quad_rx = 1'($urandom);
        end
        tx_idx = 1; rx_idx = 0;
        exp_sd = (q && qrx) ? 4'h0 : exp_grp(tx_model, 0, len, step, l);
        chk("go_tip", 64'(tip), 64'd1);
        chk("go_oe", 64'(sd_oe), 64'(exp_oe));
        chk_sd("go_sd", q, exp_sd);
        chk("go_last", 64'(last_clk), 64'(tx_idx == n));
        for (int i = 0; i < int'(n); i++) begin
            v = 4'($urandom);
            if (!lb) sd_drv = v;
            if (garbage) garbage_in();
            if (rxn) neg_e = 1'b1; else pos_e = 1'b1;
            @(negedge clk);
            pos_e = 1'b0; neg_e = 1'b0; go = 1'b0; wr_en = 1'b0;
            if (!lb)
                for (int k = 0; k < int'(step); k++)
                    exp_rx[6'(bit_pos(rx_idx, k, len, step, l))] = q ? v[2'(k)] : v[1];
            rx_idx++;
            if (txn == rxn && tx_idx < n) tx_idx++;
            exp_sd = (q && qrx) ? 4'h0 : exp_grp(tx_model, tx_idx - 1, len, step, l);
            chk_sd("rx_sd", q, exp_sd);
            if (rx_idx == n) begin
                chk("end_done", 64'(done), 64'd1);
                chk("end_tip", 64'(tip), 64'd0);
                chk("end_oe", 64'(sd_oe), 64'd0);
                chk("end_last", 64'(last_clk), 64'd0);
            end else begin
                chk("mid_done", 64'(done), 64'd0);
                chk("mid_tip", 64'(tip), 64'd1);
                chk("mid_last", 64'(last_clk), 64'(tx_idx == n));
                if (garbage) garbage_in();
                if (rxn) pos_e = 1'b1; else neg_e = 1'b1;
                @(negedge clk);
                pos_e = 1'b0; neg_e = 1'b0; go = 1'b0; wr_en = 1'b0;
                if (txn != rxn && tx_idx < n) tx_idx++;
                exp_sd = (q && qrx) ? 4'h0 : exp_grp(tx_model, tx_idx - 1, len, step, l);
                chk_sd("tx_sd", q, exp_sd);
                chk("tx_last", 64'(last_clk), 64'(tx_idx == n));
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end
        if (lb) exp_rx = tx_model & mask;
        @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
        rd_idx = 1'b0; #1;
        chk("rx_w0", 64'(rdata), 64'(exp_rx[31:0]));
        rd_idx = 1'b1; #1;
        chk("rx_w1", 64'(rdata), 64'(exp_rx[63:32]));
        chk("done_count", 64'(done_cnt - done0), 64'd1);
    endtask

    // Mid-transfer go/write must be ignored; async reset aborts silently.
    task automatic abort_test();
        logic [31:0] w;
        int unsigned done0;
        w = $urandom;
        run_xfer(8, 0, 0, 0, 1, 0, 1, 0, 1, w, 0, 32'h0, 0, 0);
        @(negedge clk);
        char_len = 6'd8; lsb = 1'b0; quad = 1'b0; quad_rx = 1'b0; go = 1'b1;
        done0 = done_cnt;
        @(negedge clk);
        go = 1'b0;
        repeat (3) begin
            pos_e = 1'b1; @(negedge clk); pos_e = 1'b0;
            neg_e = 1'b1; @(negedge clk); neg_e = 1'b0;
        end
        go = 1'b1; wr_en = 1'b1; wr_idx = 1'b0; wdata = ~w;
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        pos_e = 1'b1; @(negedge clk); pos_e = 1'b0;
        neg_e = 1'b1; @(negedge clk); neg_e = 1'b0;
        chk("abort_sd_bit3", 64'(sd_o[0]), 64'(w[3]));
        chk("abort_tip_pre", 64'(tip), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tip", 64'(tip), 64'd0);
        chk("abort_oe", 64'(sd_oe), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_last", 64'(last_clk), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tx_model = '0;
        @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - done0), 64'd0);
        rd_idx = 1'b0; #1;
        chk("abort_rx0", 64'(rdata), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; char_len = 6'd0; lsb = 1'b0; quad = 1'b0; quad_rx = 1'b0;
        tx_neg = 1'b0; rx_neg = 1'b0; pos_e = 1'b0; neg_e = 1'b0; wr_en = 1'b0;
        wr_idx = 1'b0; wdata = 32'h0; rd_idx = 1'b0; sd_drv = 4'h0;
        ext_lb = 1'b0; ext_quad = 1'b0; lb_in = 1'b0; tx_model = '0;
        repeat (3) @(negedge clk);
        chk("rst_tip", 64'(tip), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sd", 64'(sd_o), 64'd0);
        chk("rst_oe", 64'(sd_oe), 64'd0);
        chk("rst_last", 64'(last_clk), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(8, 0, 0, 0, 1, 0, 1, 0, 1, 32'h0000_00A5, 0, 32'h0, 0, 0);
        run_xfer(16, 1, 1, 0, 1, 0, 0, 0, 1, 32'h0000_1234, 0, 32'h0, 0, 0);
        run_xfer(8, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        run_xfer(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'hDEAD_BEEF, 1, 32'h0123_4567, 1, 0);
`ifdef QSPI_SHIFT_LOOPBACK_EN
        run_xfer(8, 0, 1, 0, 1, 0, 1, 1, 1, 32'h0000_005A, 0, 32'h0, 0, 0);
        lb_in = 1'b0;
`endif
        abort_test();

        repeat (40) begin
            bit q, qrx, lb;
            q   = 1'($urandom);
            qrx = q ? 1'($urandom) : 1'b0;
            lb  = qrx ? 1'b0 : 1'($urandom);
            run_xfer($urandom_range(0, 63), 1'($urandom), q, qrx, 1'($urandom), 1'($urandom),
                     lb, 1'b0, 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
